// File: rtl/fetch_redirect.sv
// IF stage: owns the PC and the IF/ID register, follows the ID-stage branch decision,
// honours hazard stalls and keeps saturating debug counters for redirects and stalls.
module fetch_redirect #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter bit          DELAY_SLOT = 1'b0,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             brSignal,
  input  logic [15:0]      Imm,
  input  logic             stall,
  input  logic [31:0]      im_dout,
  output logic [31:0]      pc,
  output logic [31:0]      IFID_Instr,
  output logic [31:0]      IFID_PC4,
  output logic             IFID_valid,
  output logic             redirect,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        take;

  assign pc_plus4 = pc + 32'd4;
  assign target   = IFID_PC4 + {{14{Imm[15]}}, Imm, 2'b00};
  // A squashed bubble carries no real branch, so its brSignal is ignored.
  assign take     = !stall && brSignal && IFID_valid;

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = RUN;
    if (stall)     state_nxt = HOLD;
    else if (take) state_nxt = FLUSH;
  end

  // NOTE: sequential state uses non-blocking assignments; reset here is synchronous, active-low.
  always_ff @(posedge clk) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc         <= RESET_PC;
      IFID_Instr <= 32'h0;
      IFID_PC4   <= 32'h0;
      IFID_valid <= 1'b0;
      redirect   <= 1'b0;
      br_cnt     <= '0;
      stall_cnt  <= '0;
    end else if (stall) begin
      if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      // The one-cycle redirect pulse must not stretch across a stall.
      if (state == FLUSH) redirect <= 1'b0;
    end else begin
      IFID_PC4 <= pc_plus4;
      if (take) begin
        pc         <= target;
        redirect   <= 1'b1;
        IFID_Instr <= DELAY_SLOT ? im_dout : 32'h0;
        IFID_valid <= DELAY_SLOT;
        if (br_cnt != '1) br_cnt <= br_cnt + CNT_W'(1);
      end else begin
        pc         <= pc_plus4;
        redirect   <= 1'b0;
        IFID_Instr <= im_dout;
        IFID_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_redirect.sv
// Directed bench: one instance without delay slot, one with, one with 2-bit counters.
// Instances not under test are held in reset; instruction memory is a fixed address hash.
module tb_fetch_redirect;

  logic        clk = 1'b0;
  logic        rst0, rst1, rst2;
  logic        br, stall;
  logic [15:0] imm;

  logic [31:0] pc0, instr0, pc40, im0;
  logic        valid0, redir0;
  logic [15:0] brc0, stc0;

  logic [31:0] pc1, instr1, pc41, im1;
  logic        valid1, redir1;
  logic [15:0] brc1, stc1;

  logic [31:0] pc2, instr2, pc42, im2;
  logic        valid2, redir2;
  logic [1:0]  brc2, stc2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign im0 = mem(pc0);
  assign im1 = mem(pc1);
  assign im2 = mem(pc2);

  fetch_redirect #(.DELAY_SLOT(1'b0), .CNT_W(16)) u_ds0 (
    .clk(clk), .rst(rst0), .brSignal(br), .Imm(imm), .stall(stall), .im_dout(im0),
    .pc(pc0), .IFID_Instr(instr0), .IFID_PC4(pc40), .IFID_valid(valid0),
    .redirect(redir0), .br_cnt(brc0), .stall_cnt(stc0));

  fetch_redirect #(.DELAY_SLOT(1'b1), .CNT_W(16)) u_ds1 (
    .clk(clk), .rst(rst1), .brSignal(br), .Imm(imm), .stall(stall), .im_dout(im1),
    .pc(pc1), .IFID_Instr(instr1), .IFID_PC4(pc41), .IFID_valid(valid1),
    .redirect(redir1), .br_cnt(brc1), .stall_cnt(stc1));

  fetch_redirect #(.DELAY_SLOT(1'b0), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst2), .brSignal(br), .Imm(imm), .stall(stall), .im_dout(im2),
    .pc(pc2), .IFID_Instr(instr2), .IFID_PC4(pc42), .IFID_valid(valid2),
    .redirect(redir2), .br_cnt(brc2), .stall_cnt(stc2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    br = 1'b0; stall = 1'b0; imm = 16'h0;

    // ---------------- DELAY_SLOT = 0 ----------------
    tick(2);
    check("rst pc",        pc0,    32'h3000);
    check("rst instr",     instr0, 32'h0);
    check("rst pc4",       pc40,   32'h0);
    check("rst valid",     valid0, 0);
    check("rst redirect",  redir0, 0);
    check("rst br_cnt",    brc0,   0);
    check("rst stall_cnt", stc0,   0);

    rst0 = 1'b1;
    tick();
    check("run1 pc",    pc0,    32'h3004);
    check("run1 pc4",   pc40,   32'h3004);
    check("run1 valid", valid0, 1);
    check("run1 instr", instr0, mem(32'h3000));
    tick();
    check("run2 pc",    pc0,    32'h3008);
    check("run2 pc4",   pc40,   32'h3008);
    check("run2 instr", instr0, mem(32'h3004));

    // Forward branch: 0x3008 + (4<<2) = 0x3018
    br = 1'b1; imm = 16'h0004;
    tick();
    check("fwd pc",       pc0,    32'h3018);
    check("fwd redirect", redir0, 1);
    check("fwd valid",    valid0, 0);
    check("fwd instr",    instr0, 32'h0);
    check("fwd pc4",      pc40,   32'h300C);
    check("fwd br_cnt",   brc0,   1);

    // Bubble in ID: branch still asserted but ignored
    tick();
    check("bub pc",       pc0,    32'h301C);
    check("bub redirect", redir0, 0);
    check("bub valid",    valid0, 1);
    check("bub instr",    instr0, mem(32'h3018));
    check("bub br_cnt",   brc0,   1);

    // Stall masks branch for 3 cycles
    stall = 1'b1; br = 1'b1; imm = 16'hFFF0;
    tick(3);
    check("stl pc",        pc0,    32'h301C);
    check("stl pc4",       pc40,   32'h301C);
    check("stl instr",     instr0, mem(32'h3018));
    check("stl stall_cnt", stc0,   3);
    check("stl br_cnt",    brc0,   1);

    // Release with branch: 0x301C - 0x40 = 0x2FDC
    stall = 1'b0;
    tick();
    check("rel pc",       pc0,    32'h2FDC);
    check("rel redirect", redir0, 1);
    check("rel br_cnt",   brc0,   2);
    check("rel valid",    valid0, 0);

    // Reset while in FLUSH, with stall and branch also asserted
    rst0 = 1'b0; stall = 1'b1;
    tick();
    check("rstf pc",        pc0,    32'h3000);
    check("rstf redirect",  redir0, 0);
    check("rstf valid",     valid0, 0);
    check("rstf pc4",       pc40,   32'h0);
    check("rstf br_cnt",    brc0,   0);
    check("rstf stall_cnt", stc0,   0);

    // Stall in FLUSH drops redirect
    rst0 = 1'b1; stall = 1'b0; br = 1'b0;
    tick();
    br = 1'b1; imm = 16'h0001;
    tick();
    check("fl pc",       pc0,    32'h3008);
    check("fl redirect", redir0, 1);
    stall = 1'b1; br = 1'b0;
    tick();
    check("flst redirect",  redir0, 0);
    check("flst pc",        pc0,    32'h3008);
    check("flst stall_cnt", stc0,   1);

    // ---------------- DELAY_SLOT = 1 ----------------
    rst0 = 1'b0; stall = 1'b0; br = 1'b0;
    tick(2);
    rst1 = 1'b1;
    tick(4);
    check("ds pc",  pc1,  32'h3010);
    check("ds pc4", pc41, 32'h3010);

    // Backward branch: 0x3010 - 0x10 = 0x3000, slot instruction kept
    br = 1'b1; imm = 16'hFFFC;
    tick();
    check("dsb pc",       pc1,    32'h3000);
    check("dsb instr",    instr1, mem(32'h3010));
    check("dsb valid",    valid1, 1);
    check("dsb redirect", redir1, 1);
    check("dsb pc4",      pc41,   32'h3014);

    // Taken branch in the slot: 0x3014 + 0x20 = 0x3034
    imm = 16'h0008;
    tick();
    check("ds2 pc",       pc1,    32'h3034);
    check("ds2 redirect", redir1, 1);
    check("ds2 br_cnt",   brc1,   2);
    check("ds2 instr",    instr1, mem(32'h3000));
    check("ds2 pc4",      pc41,   32'h3004);

    // ---------------- CNT_W = 2 saturation ----------------
    rst1 = 1'b0; br = 1'b0;
    tick(2);
    rst2 = 1'b1; stall = 1'b1;
    tick(5);
    check("sat stall_cnt", stc2, 2'd3);
    check("sat pc",        pc2,  32'h3000);

    // Branch every other cycle (bubbles in between): 4 taken, counter stops at 3
    stall = 1'b0; br = 1'b1; imm = 16'h0000;
    tick(8);
    check("sat br_cnt",    brc2, 2'd3);
    check("sat stall_hld", stc2, 2'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_redirect.md
Name: fetch_redirect

Overview:
- IF-stage consumer of the ID-stage branch decision.
- Owns the PC register and the IF/ID pipeline register.
- On a taken branch, redirects fetch to the branch target. Squashes the wrong-path instruction unless the delay slot is enabled.
- Honours hazard-unit stalls, tracks redirect/flush state, and keeps saturating event counters for debug.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
DELAY_SLOT, 0, 1 = instruction after branch is kept (MIPS delay slot); 0 = squashed
CNT_W, 16, width of the taken-branch and stall event counters

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-low (state reset when rst==0 at posedge clk)
brSignal  in  1  ID-stage branch-taken decision, sampled only when not stalled
Imm  in  16  offset field of the instruction in ID (IFID_Instr[15:0])
stall  in  1  hazard unit hold request (load-use or branch operand not yet forwardable)
im_dout  in  32  instruction memory read data for address pc
pc  out  32  current fetch address to instruction memory
IFID_Instr  out  32  instruction latched for ID
IFID_PC4  out  32  pc+4 of the instruction in ID
IFID_valid  out  1  0 when IFID_Instr is a squashed bubble
redirect  out  1  registered, high for the one cycle after a redirect was taken
br_cnt  out  CNT_W  number of taken redirects, saturating
stall_cnt  out  CNT_W  number of stalled cycles, saturating

Behaviour:
- Reset (rst==0 at posedge):
  - pc=RESET_PC.
  - IFID_Instr=32'h0, IFID_PC4=32'h0, IFID_valid=0.
  - redirect=0, br_cnt=0, stall_cnt=0.
  - State=RUN.
  - Reset wins over every other input, including mid-stall and mid-redirect.
- Target computation: target = IFID_PC4 + {{14{Imm[15]}}, Imm, 2'b00}, 32-bit with wrap-around and no overflow flag.
- Priority each cycle: reset > stall > brSignal > sequential fetch.
- State RUN:
  - stall=1:
    - pc, IFID_* and redirect hold; stall_cnt+1.
    - brSignal ignored, because ID re-evaluates after the stall.
    - Next state HOLD.
  - stall=0, brSignal=1 && IFID_valid=1:
    - pc<=target; redirect<=1; br_cnt+1.
    - IFID_PC4<=pc+4.
    - If DELAY_SLOT=0: IFID_Instr<=0, IFID_valid<=0. If DELAY_SLOT=1: IFID_Instr<=im_dout, IFID_valid<=1.
    - Next state FLUSH.
  - Otherwise:
    - pc<=pc+4, IFID_Instr<=im_dout, IFID_PC4<=pc+4, IFID_valid<=1, redirect<=0.
    - Stay in RUN.
- State HOLD:
  - Same rules as RUN. The only difference is that the stall has ended.
  - Leaves to RUN or FLUSH under the RUN conditions.
- State FLUSH:
  - redirect stays high exactly one cycle after entry.
  - Then normal fetch from target. brSignal is honoured only if IFID_valid=1.
  - A squashed bubble never produces a redirect, even if brSignal is asserted.
  - stall in FLUSH: hold, and redirect drops to 0.
- Back-to-back taken branches:
  - With DELAY_SLOT=1, a taken branch in the slot redirects again the next cycle.
  - With DELAY_SLOT=0 this is impossible because the slot is a bubble.
- pc[1:0] is always 2'b00. Imm only produces word multiples.
- Counters saturate at all-ones and never wrap.
- Latency:
  - Taken brSignal at cycle n gives pc=target after posedge n.
  - The target instruction is in IFID at n+1.
  - Taken-branch penalty is 1 bubble when DELAY_SLOT=0, 0 when DELAY_SLOT=1.

Test Plan:
- Reset then run: rst=0 for 2 cycles, then rst=1 with no stall or branch -> pc=0x3000, 0x3004, 0x3008; IFID_PC4 trails pc by one cycle; IFID_valid=1 from the second cycle after release.
- Forward taken branch: IFID_PC4=0x3008, Imm=16'h0004, brSignal=1 -> next pc=0x3018, redirect=1 for 1 cycle, IFID_valid=0 (DELAY_SLOT=0), br_cnt=1.
- Backward branch with delay slot: DELAY_SLOT=1, IFID_PC4=0x3010, Imm=16'hFFFC -> pc=0x3000, IFID_Instr=im_dout of 0x3010, IFID_valid=1.
- Stall masks branch: stall=1 and brSignal=1 for 3 cycles -> pc and IFID frozen, stall_cnt=3, br_cnt=0; on release with brSignal=1 -> redirect taken.
- Bubble ignores branch: force brSignal=1 while IFID_valid=0 after a redirect -> no second redirect; pc increments by 4.
- Reset mid-redirect and saturation: assert rst=0 in FLUSH -> all outputs return to reset values next posedge; with CNT_W=2, 5 stalled cycles -> stall_cnt=3.
